// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer for a block-stacking playfield: scans rows bottom-up,
// removes full rows by shifting everything above down one row, then blanks the top row.
module line_clear_ctrl #(
  parameter int ROWS = 20,
  parameter int COLS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [4:0] rd_row,
  output logic [3:0] rd_col,
  input  logic [3:0] rd_data,
  output logic       wr_en,
  output logic [4:0] wr_row,
  output logic [3:0] wr_col,
  output logic [3:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic [4:0] lines_cleared
);

  localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
  localparam logic [3:0] LAST_COL  = 4'(COLS - 1);
  localparam logic [4:0] MAX_LINES = 5'(ROWS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SHIFT,
    ST_CLEAR_TOP,
    ST_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] cur_row_q, cur_row_d;
  logic [3:0] col_q, col_d;
  logic [4:0] dst_q, dst_d;
  logic [4:0] lines_q, lines_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cur_row_q <= '0;
      col_q     <= '0;
      dst_q     <= '0;
      lines_q   <= '0;
    end else begin
      state_q   <= state_d;
      cur_row_q <= cur_row_d;
      col_q     <= col_d;
      dst_q     <= dst_d;
      lines_q   <= lines_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_row_d = cur_row_q;
    col_d     = col_q;
    dst_d     = dst_q;
    lines_d   = lines_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SCAN;
          cur_row_d = LAST_ROW;
          col_d     = '0;
          lines_d   = '0;
        end
      end
      ST_SCAN: begin
        if (rd_data == 4'd0) begin
          col_d = '0;
          if (cur_row_q == 5'd0) state_d = ST_DONE;
          else                   cur_row_d = cur_row_q - 5'd1;
        end else if (col_q != LAST_COL) begin
          col_d = col_q + 4'd1;
        end else begin
          // Full row: remember where it sits; cur_row stays so the row dropped into it is rescanned.
          col_d   = '0;
          dst_d   = cur_row_q;
          lines_d = (lines_q == MAX_LINES) ? lines_q : lines_q + 5'd1;
          state_d = (cur_row_q == 5'd0) ? ST_CLEAR_TOP : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (col_q == LAST_COL) begin
          col_d = '0;
          if (dst_q == 5'd1) state_d = ST_CLEAR_TOP;
          else               dst_d   = dst_q - 5'd1;
        end else begin
          col_d = col_q + 4'd1;
        end
      end
      ST_CLEAR_TOP: begin
        if (col_q == LAST_COL) begin
          col_d   = '0;
          state_d = ST_SCAN;
        end else begin
          col_d = col_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_row  = '0;
    rd_col  = '0;
    wr_en   = 1'b0;
    wr_row  = '0;
    wr_col  = '0;
    wr_data = '0;
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    case (state_q)
      ST_SCAN: begin
        rd_row = cur_row_q;
        rd_col = col_q;
      end
      ST_SHIFT: begin
        rd_row  = dst_q - 5'd1;
        rd_col  = col_q;
        wr_en   = 1'b1;
        wr_row  = dst_q;
        wr_col  = col_q;
        wr_data = rd_data;
      end
      ST_CLEAR_TOP: begin
        wr_en  = 1'b1;
        wr_col = col_q;
      end
      default: ;
    endcase
  end

  assign lines_cleared = lines_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Self-checking bench for line_clear_ctrl: a grid array driven by the DUT's ports,
// compared after each pass against a row-compaction model of the playfield.
module tb_line_clear_ctrl;

  localparam int ROWS = 20;
  localparam int COLS = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] rd_row, wr_row, lines_cleared;
  logic [3:0] rd_col, wr_col, wr_data, rd_data;
  logic       wr_en, busy, done;

  logic [3:0] grid     [ROWS][COLS];
  logic [3:0] stage    [ROWS][COLS];
  logic [3:0] exp_grid [ROWS][COLS];
  int exp_lines;

  int n_cmp = 0;
  int n_bad = 0;
  int pc_cycles, pc_scan, pc_shift, pc_clr, pc_r19;
  int pass_no = 0;

  line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .busy(busy), .done(done), .lines_cleared(lines_cleared)
  );

  always #5 clk = ~clk;

  always_comb rd_data = (int'(rd_row) < ROWS && int'(rd_col) < COLS) ? grid[rd_row][rd_col] : 4'd0;

  always @(posedge clk)
    if (wr_en && int'(wr_row) < ROWS && int'(wr_col) < COLS) grid[wr_row][wr_col] <= wr_data;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_stage();
    @(negedge clk);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        grid[r][c] <= stage[r][c];
    #1;
  endtask

  task automatic clear_stage();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        stage[r][c] = 4'd0;
  endtask

  task automatic random_stage();
    int mode;
    for (int r = 0; r < ROWS; r++) begin
      mode = $urandom_range(0, 3);
      for (int c = 0; c < COLS; c++)
        case (mode)
          0:       stage[r][c] = 4'd0;
          1:       stage[r][c] = 4'($urandom_range(1, 15));
          default: stage[r][c] = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 15)) : 4'd0;
        endcase
    end
  endtask

  // Reference: keep non-full rows in bottom-up order, stack them at the bottom, zero-fill above.
  task automatic compute_model();
    int k;
    bit full;
    exp_lines = 0;
    k = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (grid[r][c] == 4'd0) full = 1'b0;
      if (full) exp_lines++;
      else begin
        for (int c = 0; c < COLS; c++) exp_grid[k][c] = grid[r][c];
        k--;
      end
    end
    for (int r = k; r >= 0; r--)
      for (int c = 0; c < COLS; c++) exp_grid[r][c] = 4'd0;
    if (exp_lines > ROWS) exp_lines = ROWS;
  endtask

  task automatic run_pass(input bit hold);
    pc_cycles = 0; pc_scan = 0; pc_shift = 0; pc_clr = 0; pc_r19 = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    while (pc_cycles < 6000) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      pc_cycles++;
      check_val("busy_in_pass", 32'(busy), 32'd1);
      if (!wr_en) check_val("wr_data_idle", 32'(wr_data), 32'd0);
      if (done) break;
      if (!wr_en) begin
        pc_scan++;
        if (int'(rd_row) == ROWS - 1 && rd_col == 4'd0) pc_r19++;
      end else if (wr_row == 5'd0) pc_clr++;
      else pc_shift++;
    end
    check_val("done_seen", 32'(done), 32'd1);
    check_val("done_addr", {rd_row, rd_col, wr_row, wr_col, wr_en}, 32'd0);
  endtask

  task automatic check_result(input string tag);
    int bad_cells;
    bad_cells = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (grid[r][c] !== exp_grid[r][c]) bad_cells++;
    check_val({tag, "_lines"}, 32'(lines_cleared), 32'(exp_lines));
    check_val({tag, "_grid"}, 32'(bad_cells), 32'd0);
    pass_no++;
    $display("pass %0d (%s): lines=%0d exp=%0d cycles=%0d scan=%0d shift=%0d clear=%0d bad_cells=%0d",
             pass_no, tag, lines_cleared, exp_lines, pc_cycles, pc_scan, pc_shift, pc_clr, bad_cells);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check_val({tag, "_addr"}, {rd_row, rd_col, wr_row, wr_col}, 32'd0);
    check_val({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check_val({tag, "_lines"}, 32'(lines_cleared), 32'd0);
  endtask

  initial begin
    int t;
    clear_stage();
    load_stage();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Empty grid: 20 single-cycle row scans, done on the 21st cycle
    compute_model();
    run_pass(1'b0);
    check_val("empty_cycles", 32'(pc_cycles), 32'd21);
    check_val("empty_writes", 32'(pc_shift + pc_clr), 32'd0);
    check_result("empty");

    // Bottom row full, one stray cell above it
    clear_stage();
    for (int c = 0; c < COLS; c++) stage[19][c] = 4'd3;
    stage[18][4] = 4'h5;
    load_stage();
    compute_model();
    run_pass(1'b0);
    check_val("r19_scan", 32'(pc_scan), 32'd30);
    check_val("r19_shift", 32'(pc_shift), 32'd190);
    check_val("r19_clear", 32'(pc_clr), 32'd10);
    check_val("r19_cell", 32'(grid[19][4]), 32'd5);
    check_result("row19");
    repeat (3) @(negedge clk);
    check_val("lines_hold", 32'(lines_cleared), 32'd1);

    // Four full rows at the bottom
    clear_stage();
    for (int r = 16; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) stage[r][c] = 4'($urandom_range(1, 15));
    load_stage();
    compute_model();
    run_pass(1'b0);
    check_val("four_r19_scans", 32'(pc_r19), 32'd5);
    check_result("four");

    // Only the top row full: clear-top path with no shifting
    clear_stage();
    for (int c = 0; c < COLS; c++) stage[0][c] = 4'd7;
    load_stage();
    compute_model();
    run_pass(1'b0);
    check_val("top_shift", 32'(pc_shift), 32'd0);
    check_val("top_clear", 32'(pc_clr), 32'd10);
    check_val("top_scan", 32'(pc_scan), 32'd30);
    check_result("top");

    // Start held high: one pass, then the next starts right after IDLE
    clear_stage();
    load_stage();
    compute_model();
    run_pass(1'b1);
    check_result("hold");
    @(negedge clk);
    check_val("hold_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check_val("hold_restart", 32'(busy), 32'd1);
    start = 1'b0;
    t = 0;
    while (busy && t < 6000) begin @(negedge clk); t++; end
    check_val("hold_drain", 32'(busy), 32'd0);

    // Reset in the middle of SHIFT aborts at once, then a clean pass follows
    clear_stage();
    for (int c = 0; c < COLS; c++) stage[19][c] = 4'd9;
    for (int r = 0; r < 19; r++) stage[r][r % COLS] = 4'd2;
    load_stage();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (t < 60 && t < 6000) begin
      @(negedge clk);
      if (wr_en && wr_row != 5'd0) t++;
      else if (!busy) t = 6000;
    end
    check_val("mid_shift_reached", 32'(wr_en), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    compute_model();
    run_pass(1'b0);
    check_result("after_reset");

    // Randomized playfields
    for (int i = 0; i < 12; i++) begin
      random_stage();
      load_stage();
      compute_model();
      run_pass(1'b0);
      check_result("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/line_clear_ctrl.md
LINE_CLEAR_CTRL -- requirements
Module: line_clear_ctrl

Interface
REQ-001 The module SHALL have parameter ROWS, default 20, giving the number of playfield rows (row 0 = top).
REQ-002 The module SHALL have parameter COLS, default 10, giving the number of playfield columns.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request a line-clear pass; sampled on a rising clk edge.
REQ-007 rd_row  output  5  grid read row address.
REQ-008 rd_col  output  4  grid read column address.
REQ-009 rd_data  input  4  cell code at (rd_row, rd_col), combinational from the grid register array; 0 = empty.
REQ-010 wr_en  output  1  grid write strobe for one cell on the rising edge where it is high.
REQ-011 wr_row  output  5  grid write row address.
REQ-012 wr_col  output  4  grid write column address.
REQ-013 wr_data  output  4  cell code to write.
REQ-014 busy  output  1  high in every state except IDLE; game logic SHALL NOT write the grid while high.
REQ-015 done  output  1  one-cycle pulse marking the end of a pass.
REQ-016 lines_cleared  output  5  number of rows removed in the last pass, 0..ROWS.

Function
REQ-017 The FSM SHALL have states IDLE, SCAN, SHIFT, CLEAR_TOP and DONE.
REQ-018 IDLE: start=1 -> SCAN, cur_row=ROWS-1, col=0, lines_cleared=0; start is ignored in every other state.
REQ-019 SCAN: one cell per cycle, rd_row=cur_row, rd_col=col, wr_en=0.
REQ-020 SCAN, rd_data==0: row is not full; if cur_row==0 -> DONE, else cur_row-1, col=0.
REQ-021 SCAN, rd_data!=0 and col<COLS-1: col+1.
REQ-022 SCAN, rd_data!=0 and col==COLS-1: row is full; lines_cleared+1; col=0; dst=cur_row; if cur_row==0 -> CLEAR_TOP, else -> SHIFT.
REQ-023 SHIFT: one cell per cycle, rd_row=dst-1, wr_row=dst, rd_col=wr_col=col, wr_data=rd_data, wr_en=1.
REQ-024 SHIFT: col wraps COLS-1 -> 0 with dst-1; after writing (dst=1, col=COLS-1) -> CLEAR_TOP, col=0.
REQ-025 CLEAR_TOP: wr_row=0, wr_col=col, wr_data=0, wr_en=1 for COLS cycles; after col==COLS-1 -> SCAN at the same cur_row, col=0, so the row moved down is rescanned.
REQ-026 DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
REQ-027 lines_cleared SHALL hold its value from DONE until the next accepted start.
REQ-028 wr_en SHALL be 0 in IDLE, SCAN and DONE; no cell is written twice in the same cycle.
REQ-029 Address outputs in IDLE and DONE SHALL be 0; wr_data SHALL be 0 whenever wr_en=0.
REQ-030 The lines_cleared counter SHALL saturate at ROWS.

Reset
REQ-031 rst_n low SHALL force IDLE asynchronously: busy=0, done=0, wr_en=0, all addresses 0, wr_data=0, lines_cleared=0.
REQ-032 Reset during SHIFT or CLEAR_TOP SHALL abort immediately; the partially shifted grid is not restored, and the next start rescans from the bottom.
REQ-033 After rst_n releases, the first start SHALL be accepted on the first rising edge on which it is sampled high.

Verification
REQ-034 Empty grid, start pulse -> 20 SCAN cycles, then done=1 on the 21st cycle after the start edge, lines_cleared=0, wr_en never 1.
REQ-035 Only row 19 full (code 3), row 18 = 0x5 in col 4 only -> 10 SCAN + 190 SHIFT + 10 CLEAR_TOP + 20 SCAN cycles, then done; lines_cleared=1; row 19 col 4 = 5; all other cells 0.
REQ-036 Rows 16-19 full, rows 0-15 empty -> lines_cleared=4; whole grid 0 at done; row 19 scanned 5 times.
REQ-037 Row 0 only full -> no SHIFT cycles; 10 CLEAR_TOP writes, then a rescan of row 0; lines_cleared=1; grid empty.
REQ-038 start held high through the whole pass -> exactly one pass; a new pass starts on the first edge after the return to IDLE.
REQ-039 rst_n asserted in the middle of SHIFT -> wr_en=0 and busy=0 with no clock edge; all outputs at their reset values; a following start completes a clean pass.
